// File: rtl/oc8051_uart_peer_if.sv
// rtl/oc8051_uart_peer_if.sv - host-side handshake bundle for the 8051 UART peer
interface oc8051_uart_peer_if;
    logic [8:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [8:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid, frame_err, overrun
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid, frame_err, overrun
    );
endinterface

// File: rtl/oc8051_uart_peer.sv
// rtl/oc8051_uart_peer.sv - off-chip async serial endpoint for 8051 serial modes 1/2/3
module oc8051_uart_peer #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic nine_bit,
    output logic txd,
    input  logic rxd,
    oc8051_uart_peer_if.slave bus
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] div_cnt;
    logic          tick;

    assign tick = (div_cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    typedef enum logic [2:0] {
        TX_IDLE, TX_PEND, TX_START, TX_DATA, TX_BIT9, TX_STOP
    } tx_state_t;

    tx_state_t  tx_state, tx_state_n;
    logic [3:0] tx_tcnt, tx_tcnt_n;
    logic [2:0] tx_bcnt, tx_bcnt_n;
    logic [8:0] tx_shift, tx_shift_n;
    logic       tx_nine, tx_nine_n;
    logic       txd_q, txd_n;
    logic       tx_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_tcnt  <= '0;
            tx_bcnt  <= '0;
            tx_shift <= '0;
            tx_nine  <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_tcnt  <= tx_tcnt_n;
            tx_bcnt  <= tx_bcnt_n;
            tx_shift <= tx_shift_n;
            tx_nine  <= tx_nine_n;
            txd_q    <= txd_n;
        end
    end

    // txd is registered from the next-state decode so the line never glitches
    always_comb begin
        tx_state_n = tx_state;
        tx_tcnt_n  = tx_tcnt;
        tx_bcnt_n  = tx_bcnt;
        tx_shift_n = tx_shift;
        tx_nine_n  = tx_nine;
        txd_n      = txd_q;
        tx_last    = tick && (tx_tcnt == 4'd15);
        if (tick && tx_state != TX_IDLE && tx_state != TX_PEND)
            tx_tcnt_n = tx_tcnt + 4'd1;
        case (tx_state)
            TX_IDLE: begin
                txd_n = 1'b1;
                if (bus.tx_valid) begin
                    tx_state_n = TX_PEND;
                    tx_shift_n = bus.tx_data;
                    tx_nine_n  = nine_bit;
                end
            end
            TX_PEND: begin
                if (tick) begin
                    tx_state_n = TX_START;
                    tx_tcnt_n  = 4'd0;
                    txd_n      = 1'b0;
                end
            end
            TX_START: begin
                if (tx_last) begin
                    tx_state_n = TX_DATA;
                    tx_bcnt_n  = 3'd0;
                    txd_n      = tx_shift[0];
                end
            end
            TX_DATA: begin
                if (tx_last) begin
                    tx_shift_n = tx_shift >> 1;
                    if (tx_bcnt == 3'd7) begin
                        tx_state_n = tx_nine ? TX_BIT9 : TX_STOP;
                        txd_n      = tx_nine ? tx_shift[1] : 1'b1;
                    end else begin
                        tx_bcnt_n = tx_bcnt + 3'd1;
                        txd_n     = tx_shift[1];
                    end
                end
            end
            TX_BIT9: begin
                if (tx_last) begin
                    tx_state_n = TX_STOP;
                    txd_n      = 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_last) tx_state_n = TX_IDLE;
            end
            default: begin
                tx_state_n = TX_IDLE;
                txd_n      = 1'b1;
            end
        endcase
    end

    assign txd          = txd_q;
    assign bus.tx_ready = (tx_state == TX_IDLE);

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_BIT9, RX_STOP
    } rx_state_t;

    rx_state_t  rx_state, rx_state_n;
    logic       rx_meta, rx_sync, rx_prev;
    logic [3:0] rx_tcnt, rx_tcnt_n, rx_idx;
    logic [2:0] rx_bcnt, rx_bcnt_n;
    logic [8:0] rx_shift, rx_shift_n;
    logic       rx_nine, rx_nine_n;
    logic       s7, s7_n, s8, s8_n;
    logic       maj, decide, bit_end, rx_done, rx_ferr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_tcnt  <= '0;
            rx_bcnt  <= '0;
            rx_shift <= '0;
            rx_nine  <= 1'b0;
            s7       <= 1'b1;
            s8       <= 1'b1;
        end else begin
            rx_meta  <= rxd;
            rx_sync  <= rx_meta;
            if (tick) rx_prev <= rx_sync;
            rx_state <= rx_state_n;
            rx_tcnt  <= rx_tcnt_n;
            rx_bcnt  <= rx_bcnt_n;
            rx_shift <= rx_shift_n;
            rx_nine  <= rx_nine_n;
            s7       <= s7_n;
            s8       <= s8_n;
        end
    end

    // rx_idx is the position of the current tick within the bit; 0 marks a bit boundary
    always_comb begin
        rx_state_n = rx_state;
        rx_tcnt_n  = rx_tcnt;
        rx_bcnt_n  = rx_bcnt;
        rx_shift_n = rx_shift;
        rx_nine_n  = rx_nine;
        s7_n       = s7;
        s8_n       = s8;
        rx_done    = 1'b0;
        rx_ferr    = 1'b0;
        rx_idx     = rx_tcnt + 4'd1;
        maj        = (s7 & s8) | (s7 & rx_sync) | (s8 & rx_sync);
        decide     = tick && (rx_idx == 4'd9);
        bit_end    = tick && (rx_idx == 4'd0);
        if (tick && rx_state != RX_IDLE) begin
            rx_tcnt_n = rx_idx;
            if (rx_idx == 4'd7) s7_n = rx_sync;
            if (rx_idx == 4'd8) s8_n = rx_sync;
        end
        case (rx_state)
            RX_IDLE: begin
                if (tick && rx_prev && !rx_sync) begin
                    rx_state_n = RX_START;
                    rx_tcnt_n  = 4'd0;
                    rx_nine_n  = nine_bit;
                    rx_shift_n = '0;
                end
            end
            RX_START: begin
                if (decide && maj) begin
                    rx_state_n = RX_IDLE;
                end else if (bit_end) begin
                    rx_state_n = RX_DATA;
                    rx_bcnt_n  = 3'd0;
                end
            end
            RX_DATA: begin
                if (decide) rx_shift_n[rx_bcnt] = maj;
                if (bit_end) begin
                    if (rx_bcnt == 3'd7) rx_state_n = rx_nine ? RX_BIT9 : RX_STOP;
                    else                 rx_bcnt_n  = rx_bcnt + 3'd1;
                end
            end
            RX_BIT9: begin
                if (decide)  rx_shift_n[8] = maj;
                if (bit_end) rx_state_n    = RX_STOP;
            end
            RX_STOP: begin
                if (decide) begin
                    rx_state_n = RX_IDLE;
                    rx_done    = maj;
                    rx_ferr    = !maj;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rx_data   <= '0;
            bus.rx_valid  <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.frame_err <= rx_ferr;
            bus.overrun   <= rx_done && bus.rx_valid && !bus.rx_ready;
            if (rx_done && !(bus.rx_valid && !bus.rx_ready)) begin
                bus.rx_data  <= rx_shift;
                bus.rx_valid <= 1'b1;
            end else if (bus.rx_valid && bus.rx_ready) begin
                bus.rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_oc8051_uart_peer.sv
// tb/tb_oc8051_uart_peer.sv - randomized self-checking bench for oc8051_uart_peer
module tb_oc8051_uart_peer;

    localparam int DIV = 4;
    localparam int BIT = 16 * DIV;

    logic clk = 1'b0;
    logic rst;
    logic nine_bit;
    logic txd;
    logic rxd;
    logic loop_en;
    logic rxd_drv;

    int n_cmp = 0;
    int n_err = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    logic [8:0] exp_q[$];

    oc8051_uart_peer_if bus();

    oc8051_uart_peer #(.CLK_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .nine_bit (nine_bit),
        .txd      (txd),
        .rxd      (rxd),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    assign rxd = loop_en ? txd : rxd_drv;

    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) fe_cnt++;
        if (bus.overrun === 1'b1)   ov_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_tx(input logic [8:0] d, input logic nine);
        int t;
        t = 0;
        while (bus.tx_ready !== 1'b1 && t < 2000) begin step(1); t++; end
        if (t >= 2000) check("tx_ready_timeout", 0, 1);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        nine_bit     = nine;
        step(1);
        bus.tx_valid = 1'b0;
        bus.tx_data  = $urandom;
    endtask

    // Expected line: start 0, data LSB first, optional 9th bit, stop 1
    task automatic check_tx_frame(input logic [8:0] d, input logic nine, input string tag);
        int t, n, el;
        logic e;
        n = nine ? 11 : 10;
        t = 0;
        while (txd !== 1'b0 && t < 200) begin step(1); t++; end
        if (t >= 200) begin
            check({tag, "_start_timeout"}, 0, 1);
            return;
        end
        el = 0;
        for (int k = 0; k < n; k++) begin
            step(k == 0 ? BIT / 2 : BIT);
            el += (k == 0) ? BIT / 2 : BIT;
            if (k == 0)      e = 1'b0;
            else if (k <= 8) e = d[k-1];
            else if (k == 9 && nine) e = d[8];
            else             e = 1'b1;
            check($sformatf("%s_bit%0d", tag, k), txd, e);
        end
        while (bus.tx_ready !== 1'b1 && el < 2000) begin step(1); el++; end
        check({tag, "_len"}, el, BIT * n);
    endtask

    task automatic drive_rx(input logic [8:0] d, input logic nine, input logic stop);
        rxd_drv = 1'b0;
        step(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = d[i];
            step(BIT);
        end
        if (nine) begin
            rxd_drv = d[8];
            step(BIT);
        end
        rxd_drv = stop;
        step(BIT);
        rxd_drv = 1'b1;
    endtask

    task automatic consume(input string tag);
        logic [8:0] e;
        check({tag, "_valid"}, bus.rx_valid, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_data"}, bus.rx_data, e);
        end
        bus.rx_ready = 1'b1;
        step(1);
        bus.rx_ready = 1'b0;
        check({tag, "_cleared"}, bus.rx_valid, 0);
    endtask

    initial begin
        int fe0, ov0;
        logic [8:0] d;
        logic nb;

        rst = 1'b0;
        nine_bit = 1'b0;
        loop_en = 1'b0;
        rxd_drv = 1'b1;
        bus.tx_data = '0;
        bus.tx_valid = 1'b0;
        bus.rx_ready = 1'b0;
        step(3);
        check("rst_txd", txd, 1);
        check("rst_tx_ready", bus.tx_ready, 1);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_frame_err", bus.frame_err, 0);
        check("rst_overrun", bus.overrun, 0);
        rst = 1'b1;
        step(2);

        send_tx(9'h0A5, 1'b0);
        check("t1_busy", bus.tx_ready, 0);
        check_tx_frame(9'h0A5, 1'b0, "t1");
        check("t1_no_rx", bus.rx_valid, 0);

        loop_en = 1'b1;
        fe0 = fe_cnt;
        send_tx(9'h13C, 1'b1);
        exp_q.push_back(9'h13C);
        check_tx_frame(9'h13C, 1'b1, "t2");
        check("t2_no_ferr", fe_cnt - fe0, 0);
        consume("t2");

        for (int i = 0; i < 6; i++) begin
            d  = 9'($urandom);
            nb = 1'($urandom);
            send_tx(d, nb);
            exp_q.push_back(nb ? d : {1'b0, d[7:0]});
            check_tx_frame(d, nb, $sformatf("lb%0d", i));
            consume($sformatf("lb%0d", i));
        end
        loop_en = 1'b0;
        step(10);

        fe0 = fe_cnt;
        rxd_drv = 1'b0;
        step(20);
        rxd_drv = 1'b1;
        step(200);
        check("t3_no_valid", bus.rx_valid, 0);
        check("t3_no_ferr", fe_cnt - fe0, 0);
        nine_bit = 1'b0;
        drive_rx(9'h0C3, 1'b0, 1'b1);
        exp_q.push_back(9'h0C3);
        step(4);
        consume("t3_after");

        for (int i = 0; i < 3; i++) begin
            d  = 9'($urandom);
            nb = 1'($urandom);
            nine_bit = nb;
            drive_rx(d, nb, 1'b1);
            exp_q.push_back(nb ? d : {1'b0, d[7:0]});
            step(4);
            consume($sformatf("rx%0d", i));
        end
        nine_bit = 1'b0;

        fe0 = fe_cnt;
        drive_rx(9'h055, 1'b0, 1'b0);
        step(BIT);
        check("t4_ferr_once", fe_cnt - fe0, 1);
        check("t4_no_valid", bus.rx_valid, 0);

        ov0 = ov_cnt;
        drive_rx(9'h011, 1'b0, 1'b1);
        drive_rx(9'h022, 1'b0, 1'b1);
        step(20);
        check("t5_ov_once", ov_cnt - ov0, 1);
        check("t5_valid", bus.rx_valid, 1);
        check("t5_data_kept", bus.rx_data, 9'h011);
        bus.rx_ready = 1'b1;
        step(1);
        bus.rx_ready = 1'b0;
        check("t5_cleared", bus.rx_valid, 0);

        send_tx(9'h000, 1'b0);
        begin
            int t;
            t = 0;
            while (txd !== 1'b0 && t < 200) begin step(1); t++; end
            check("t6_start_seen", t < 200, 1);
        end
        step(BIT / 2 + 4 * BIT);
        check("t6_pre_txd", txd, 0);
        rst = 1'b0;
        #1;
        check("t6_rst_txd", txd, 1);
        check("t6_rst_ready", bus.tx_ready, 1);
        step(2);
        rst = 1'b1;
        step(2);
        check("t6_ready_after", bus.tx_ready, 1);
        check("t6_txd_idle", txd, 1);
        send_tx(9'h0FF, 1'b0);
        check_tx_frame(9'h0FF, 1'b0, "t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
